uart_param: RTL and testbench

Parametrised full-duplex UART serving as the general-purpose serial port of the GPIO subsystem. It has a configurable data width, parity mode and stop-bit count. The transmitter uses a valid/ready handshake, so any producer (CPU bus bridge, FIFO) can stream bytes back-to-back. The receiver synchronises the input line, rejects start-bit glitches, and reports parity and framing errors alongside each received word.

---
 rtl/uart_param.sv | 126 ++++++++++++
 tb/tb_uart_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_param.sv
// uart_param: full-duplex UART with configurable data width, parity mode and stop-bit count.
module uart_param #(
  parameter int CLK_DIV   = 234,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] C_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [3:0] D_END = 4'(DATA_BITS - 1);
  localparam logic [3:0] S_END = 4'(STOP_BITS - 1);
  localparam bit P = PARITY != 0;
  localparam logic ODD = PARITY == 1;

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_st_t;
  typedef enum logic [2:0] {R_IDLE, R_CHK, R_DATA, R_PAR, R_STOP, R_BRK} rx_st_t;

  tx_st_t tx_st, tx_nx;
  logic [CW-1:0] tx_cnt;
  logic [3:0] tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic tx_par, tx_tick, tx_last, tx_go;

  always_comb begin
    tx_tick = tx_cnt == C_END;
    tx_last = tx_st == T_STOP && tx_tick && tx_bit == S_END;
    tx_ready = tx_st == T_IDLE || tx_last;
    tx_go = tx_valid && tx_ready;
    tx_nx = tx_st;
    case (tx_st)
      T_IDLE:  tx_nx = tx_go ? T_START : T_IDLE;
      T_START: tx_nx = tx_tick ? T_DATA : T_START;
      T_DATA:  tx_nx = tx_tick && tx_bit == D_END ? (P ? T_PAR : T_STOP) : T_DATA;
      T_PAR:   tx_nx = tx_tick ? T_STOP : T_PAR;
      T_STOP:  tx_nx = tx_last ? (tx_go ? T_START : T_IDLE) : T_STOP;
      default: tx_nx = T_IDLE;
    endcase
  end

  // uart_tx is loaded with the level of the state being entered, so it is already valid one edge after the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st <= T_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      tx_par <= 1'b0;
      uart_tx <= 1'b1;
    end else begin
      tx_st <= tx_nx;
      tx_cnt <= tx_st == T_IDLE || tx_tick ? '0 : tx_cnt + 1'b1;
      tx_bit <= tx_nx != tx_st ? '0 : tx_tick ? tx_bit + 1'b1 : tx_bit;
      if (tx_go) begin
        tx_sh <= tx_data;
        tx_par <= ^tx_data ^ ODD;
      end else if (tx_tick && tx_st == T_DATA) tx_sh <= tx_sh >> 1;
      if (tx_go || tx_tick)
        uart_tx <= tx_nx == T_START ? 1'b0 :
                   tx_nx == T_DATA ? (tx_st == T_DATA ? tx_sh[1] : tx_sh[0]) :
                   tx_nx == T_PAR ? tx_par : 1'b1;
    end
  end

  rx_st_t rx_st, rx_nx;
  logic [1:0] sync;
  logic [CW-1:0] rx_cnt;
  logic [3:0] rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic rs, rx_pbit, rx_samp;

  always_comb begin
    rs = sync[1];
    rx_samp = rx_cnt == (rx_st == R_CHK ? C_HALF : C_END);
    rx_nx = rx_st;
    case (rx_st)
      R_IDLE:  rx_nx = rs ? R_IDLE : R_CHK;
      R_CHK:   rx_nx = rx_samp ? (rs ? R_IDLE : R_DATA) : R_CHK;
      R_DATA:  rx_nx = rx_samp && rx_bit == D_END ? (P ? R_PAR : R_STOP) : R_DATA;
      R_PAR:   rx_nx = rx_samp ? R_STOP : R_PAR;
      R_STOP:  rx_nx = rx_samp ? (rs ? R_IDLE : R_BRK) : R_STOP;
      R_BRK:   rx_nx = rs ? R_IDLE : R_BRK;
      default: rx_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      rx_st <= R_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_pbit <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      sync <= {sync[0], uart_rx};
      rx_st <= rx_nx;
      rx_cnt <= rx_st == R_IDLE || rx_st == R_BRK || rx_samp ? '0 : rx_cnt + 1'b1;
      rx_bit <= rx_st != R_DATA ? '0 : rx_samp ? rx_bit + 1'b1 : rx_bit;
      rx_valid <= rx_st == R_STOP && rx_samp;
      if (rx_samp && rx_st == R_DATA) rx_sh <= {rs, rx_sh[DATA_BITS-1:1]};
      if (rx_samp && rx_st == R_PAR) rx_pbit <= rs;
      if (rx_samp && rx_st == R_STOP) begin
        rx_data <= rx_sh;
        rx_parity_err <= P && (^rx_sh ^ rx_pbit ^ ODD);
        rx_frame_err <= !rs;
      end
    end
  end
endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: randomized self-checking bench for uart_param (8N1 and 8E1 instances, CLK_DIV=16).
module tb_uart_param;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic rx_n = 1'b1, rx_e = 1'b1, tv_n = 1'b0, tv_e = 1'b0;
  logic [7:0] td_n = '0, td_e = '0;
  logic tx_n, tx_e, rdy_n, rdy_e, rv_n, rv_e, pe_n, pe_e, fe_n, fe_e;
  logic [7:0] rd_n, rd_e;

  uart_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n (
    .clk(clk), .rst(rst), .uart_rx(rx_n), .uart_tx(tx_n), .tx_data(td_n), .tx_valid(tv_n),
    .tx_ready(rdy_n), .rx_data(rd_n), .rx_valid(rv_n), .rx_parity_err(pe_n), .rx_frame_err(fe_n));
  uart_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e (
    .clk(clk), .rst(rst), .uart_rx(rx_e), .uart_tx(tx_e), .tx_data(td_e), .tx_valid(tv_e),
    .tx_ready(rdy_e), .rx_data(rd_e), .rx_valid(rv_e), .rx_parity_err(pe_e), .rx_frame_err(fe_e));

  int passed = 0, total = 0, cyc = 0;
  typedef struct {int c; logic [7:0] d; logic pe; logic fe;} rx_t;
  rx_t qn[$], qe[$];
  logic [7:0] txq[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rv_n) qn.push_back(rx_t'{cyc, rd_n, pe_n, fe_n});
    if (rv_e) qe.push_back(rx_t'{cyc, rd_e, pe_e, fe_e});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    else passed++;
  endtask

  // Line level of frame bit i: start, data LSB first, even parity (if enabled), stop
  function automatic logic fbit(input logic [7:0] d, input bit par, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (par && i == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic tx_burst(input bit s);
    int n, L;
    logic [7:0] w;
    n = txq.size();
    L = (10 + int'(s)) * 16;
    @(negedge clk);
    w = txq.pop_front();
    if (s) begin tv_e = 1'b1; td_e = w; end else begin tv_n = 1'b1; td_n = w; end
    chk("tx_ready_idle", 32'(s ? rdy_e : rdy_n), 1);
    for (int f = 0; f < n; f++)
      for (int j = 0; j < L; j++) begin
        @(negedge clk);
        chk("tx_bit", 32'(s ? tx_e : tx_n), 32'(fbit(w, s, j / 16)));
        chk("tx_ready", 32'(s ? rdy_e : rdy_n), 32'(j == L - 1));
        if (j == 0) begin if (s) td_e = ~w; else td_n = ~w; end
        if (j == L - 1) begin
          if (f < n - 1) begin
            w = txq.pop_front();
            if (s) td_e = w; else td_n = w;
          end else if (s) tv_e = 1'b0;
          else tv_n = 1'b0;
        end
      end
    repeat (3) begin
      @(negedge clk);
      chk("tx_idle_line", 32'(s ? tx_e : tx_n), 1);
      chk("tx_idle_ready", 32'(s ? rdy_e : rdy_n), 1);
    end
  endtask

  task automatic rx_frame(input bit s, input logic [7:0] d, input bit flip, input bit stop0);
    int nb, p0, ke, k, n0;
    logic b;
    rx_t e;
    nb = 10 + int'(s);
    n0 = s ? qe.size() : qn.size();
    @(posedge clk);
    #1 p0 = cyc;
    for (int i = 0; i < nb; i++) begin
      b = fbit(d, s, i);
      if (flip && i == 9) b = ~b;
      if (stop0 && i == nb - 1) b = 1'b0;
      if (s) rx_e = b; else rx_n = b;
      repeat (16) @(posedge clk);
      #1;
    end
    if (stop0) begin
      repeat (40) @(posedge clk);
      #1;
    end
    if (s) rx_e = 1'b1; else rx_n = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    chk("rx_count", (s ? qe.size() : qn.size()) - n0, 1);
    if ((s ? qe.size() : qn.size()) > n0) begin
      e = s ? qe[qe.size()-1] : qn[qn.size()-1];
      ke = 3 + 8 + (nb - 1) * 16;
      k = e.c - p0;
      chk("rx_latency", (k == ke || k == ke - 1) ? ke : k, ke);
      chk("rx_data", 32'(e.d), 32'(d));
      chk("rx_parity_err", 32'(e.pe), 32'(s && flip));
      chk("rx_frame_err", 32'(e.fe), 32'(stop0));
      chk("rx_data_held", 32'(s ? rd_e : rd_n), 32'(d));
    end
    if (s) qe.delete(); else qn.delete();
  endtask

  initial begin
    bit s, f1, f2, st1;
    logic [7:0] d1, d2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx_n), 1);
    chk("rst_ready", 32'(rdy_n), 1);
    chk("rst_rx_valid", 32'(rv_n), 0);
    chk("rst_rx_data", 32'(rd_n), 0);
    chk("rst_perr", 32'(pe_e), 0);
    chk("rst_ferr", 32'(fe_n), 0);
    rst = 1'b0;

    txq = '{8'hA5};
    tx_burst(0);
    txq = '{8'h55, 8'h0F};
    tx_burst(0);
    txq = '{8'hC3, 8'h5A};
    tx_burst(1);

    // mid-frame reset: cycle 50 of an 0xA5 frame
    @(negedge clk);
    tv_n = 1'b1;
    td_n = 8'hA5;
    @(negedge clk);
    tv_n = 1'b0;
    repeat (49) @(posedge clk);
    #2 chk("busy_before_rst", 32'(rdy_n), 0);
    rst = 1'b1;
    #1 chk("async_rst_tx", 32'(tx_n), 1);
    chk("async_rst_ready", 32'(rdy_n), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("quiet_after_rst", 32'(tx_n), 1);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    txq = '{8'h3B};
    tx_burst(0);

    rx_frame(1, 8'h3C, 0, 0);
    rx_frame(1, 8'h3C, 1, 0);
    rx_frame(0, 8'h81, 0, 1);

    @(posedge clk);
    #1 rx_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 chk("glitch_ignored", qn.size(), 0);
    rx_frame(0, 8'h7E, 0, 0);

    for (int r = 0; r < 6; r++) begin
      s = 1'($urandom_range(0, 1));
      txq.delete();
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) txq.push_back(8'($urandom));
      d1 = 8'($urandom);
      d2 = 8'($urandom);
      f1 = s && $urandom_range(0, 1) == 1;
      f2 = !s && $urandom_range(0, 1) == 1;
      st1 = $urandom_range(0, 3) == 0;
      fork
        tx_burst(s);
        rx_frame(s, d1, f1, st1);
        rx_frame(!s, d2, f2, 1'b0);
      join
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
